dwt_row_framer: RTL
===================

Name: dwt_row_framer

Overview:
- Frame sequencer in front of the row-direction 9/7 DWT lifting pipeline.
- Accepts an unframed stream of {odd, even} sample pairs. Configures the frame size per start and generates sof/eol framing on the pipeline input.
- Passes the pipeline's result stream downstream and counts completed result rows, so it knows when the frame has fully drained.
- Reports busy/done/error to the tile controller.

Parameters:
- DataWidth, 16, bits per sample; each stream beat carries 2*DataWidth bits.
- MaximumSideSize, 512, maximum frame width and height in samples.
- CntWidth, $clog2(MaximumSideSize)+1, width of the config and counter fields (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle frame start; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns the block to IDLE.
- cfg_width_i  in  CntWidth  pairs per row; captured on an accepted start.
- cfg_height_i  in  CntWidth  rows per frame; captured on an accepted start.
- busy_o  out  1  high in FEED and DRAIN.
- done_o  out  1  one-cycle pulse when the frame has drained.
- cfg_err_o  out  1  one-cycle pulse when a start is rejected.
- s_ready_o, s_valid_i, s_data_i[2*DataWidth]  in/out  raw pair input stream.
- m_ready_i, m_valid_o, m_sof_o, m_eol_o, m_data_o[2*DataWidth]  out/in  framed stream to the DWT.
- r_ready_o, r_valid_i, r_sof_i, r_eol_i, r_data_i[2*DataWidth]  out/in  DWT result stream.
- d_ready_i, d_valid_o, d_sof_o, d_eol_o, d_data_o[2*DataWidth]  in/out  result stream to downstream.

Behaviour:
- Reset: state IDLE, all counters 0. busy_o, done_o, cfg_err_o, s_ready_o and m_valid_o are 0.
- Handshakes: a beat transfers when valid&&ready on the same edge. Both paths are combinational (zero latency, no storage). Valid must not depend on ready.
- FSM IDLE -> FEED:
  - On start_i with 4 <= cfg_width_i <= MaximumSideSize/2 and 1 <= cfg_height_i <= MaximumSideSize.
  - Latch width W and height H; clear col, row and rrow counters.
- Rejected start: if either config value is outside those ranges, pulse cfg_err_o the next cycle and stay in IDLE.
- FEED:
  - m_valid_o = s_valid_i, s_ready_o = m_ready_i, m_data_o = s_data_i.
  - m_sof_o = (row==0 && col==0). m_eol_o = (col==W-1). Both are valid only while m_valid_o is high.
  - Each transfer increments col. On col==W-1, col wraps to 0 and row increments.
  - Transfer with col==W-1 and row==H-1 -> DRAIN.
- Outside FEED: s_ready_o=0, m_valid_o=0, m_sof_o=0, m_eol_o=0.
- Result path (always, in every state):
  - d_valid_o=r_valid_i, r_ready_o=d_ready_i, and d_sof_o, d_eol_o, d_data_o mirror the r_* inputs.
  - While busy_o, each transfer with r_eol_i increments rrow. rrow saturates at H.
- DRAIN: when rrow==H (including rrow reaching H in the same cycle as the last FEED beat) -> DONE.
- DONE: done_o=1 for exactly one cycle, then -> IDLE. start_i is ignored in DONE.
- abort_i:
  - In any state except IDLE: next state IDLE, counters cleared, no done_o.
  - In IDLE: suppresses start_i in the same cycle.
- busy_o = (state==FEED || state==DRAIN), registered from the state.
- Asynchronous reset mid-frame: all state is lost immediately and outputs return to reset values. Any in-flight beat is not guaranteed.
- Config inputs are ignored outside the IDLE start cycle; changing them mid-frame has no effect.

Test Plan:
- W=4, H=2, source and sinks always ready, 8 pair beats -> m_sof_o on beat 0 only, m_eol_o on beats 3 and 7, busy_o high from the cycle after start. Return 2 rows with r_eol_i -> done_o pulses once, one cycle after the 2nd result eol.
- W=3, H=1 start, then W=4, H=0 start -> cfg_err_o pulses each time, busy_o stays 0, s_ready_o stays 0.
- W=8, H=4 with random s_valid_i and m_ready_i stalls (50%) -> exactly 32 m-beats, eol every 8th transfer, s_data_i passed bit-exact. No beat accepted after the 32nd.
- W=4, H=1, the last FEED beat and the only result eol in the same cycle -> DRAIN lasts ≤1 cycle, done_o the following cycle.
- abort_i asserted after 5 of 16 beats (W=4, H=4) -> IDLE next cycle, s_ready_o=0, no done_o. A following start with W=4, H=1 produces a fresh m_sof_o on its first beat.
- rst_i asserted asynchronously mid-FEED -> busy_o, m_valid_o and s_ready_o drop without waiting for a clock edge. A new start after reset release frames correctly.

Source files
------------

// File: rtl/dwt_row_framer.sv
// Frame sequencer in front of the row-direction 9/7 DWT lifting pipeline.
// Adds sof/eol framing to a raw pair stream and tracks result rows until the frame drains.
module dwt_row_framer #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 512,
   parameter int CntWidth        = $clog2(MaximumSideSize) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [CntWidth-1:0]    cfg_width_i,
   input  logic [CntWidth-1:0]    cfg_height_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   cfg_err_o,
   output logic                   s_ready_o,
   input  logic                   s_valid_i,
   input  logic [2*DataWidth-1:0] s_data_i,
   input  logic                   m_ready_i,
   output logic                   m_valid_o,
   output logic                   m_sof_o,
   output logic                   m_eol_o,
   output logic [2*DataWidth-1:0] m_data_o,
   output logic                   r_ready_o,
   input  logic                   r_valid_i,
   input  logic                   r_sof_i,
   input  logic                   r_eol_i,
   input  logic [2*DataWidth-1:0] r_data_i,
   input  logic                   d_ready_i,
   output logic                   d_valid_o,
   output logic                   d_sof_o,
   output logic                   d_eol_o,
   output logic [2*DataWidth-1:0] d_data_o
);

   localparam logic [CntWidth-1:0] MinWidth  = CntWidth'(4);
   localparam logic [CntWidth-1:0] MaxWidth  = CntWidth'(MaximumSideSize / 2);
   localparam logic [CntWidth-1:0] MaxHeight = CntWidth'(MaximumSideSize);
   localparam logic [CntWidth-1:0] One       = CntWidth'(1);

   typedef enum logic [1:0] {
      StIdle,
      StFeed,
      StDrain,
      StDone
   } state_t;

   state_t              r_state;
   logic [CntWidth-1:0] r_width;
   logic [CntWidth-1:0] r_height;
   logic [CntWidth-1:0] r_col;
   logic [CntWidth-1:0] r_row;
   logic [CntWidth-1:0] r_rrow;
   logic                r_cfgErr;

   logic                w_inFeed;
   logic                w_busy;
   logic                w_cfgOk;
   logic                w_lastCol;
   logic                w_lastRow;
   logic                w_mXfer;
   logic                w_rEolXfer;
   logic [CntWidth-1:0] w_rrowNext;

   assign w_inFeed   = (r_state == StFeed);
   assign w_busy     = (r_state == StFeed) || (r_state == StDrain);
   assign w_cfgOk    = (cfg_width_i >= MinWidth) && (cfg_width_i <= MaxWidth) &&
                       (cfg_height_i >= One) && (cfg_height_i <= MaxHeight);
   assign w_lastCol  = (r_col == r_width - One);
   assign w_lastRow  = (r_row == r_height - One);
   assign w_mXfer    = w_inFeed && s_valid_i && m_ready_i;
   assign w_rEolXfer = w_busy && r_valid_i && d_ready_i && r_eol_i;
   // Result row count saturates at the frame height.
   assign w_rrowNext = (w_rEolXfer && (r_rrow != r_height)) ? r_rrow + One : r_rrow;

   assign busy_o    = w_busy;
   assign done_o    = (r_state == StDone);
   assign cfg_err_o = r_cfgErr;

   assign s_ready_o = w_inFeed && m_ready_i;
   assign m_valid_o = w_inFeed && s_valid_i;
   assign m_sof_o   = w_inFeed && s_valid_i && (r_row == '0) && (r_col == '0);
   assign m_eol_o   = w_inFeed && s_valid_i && w_lastCol;
   assign m_data_o  = s_data_i;

   assign d_valid_o = r_valid_i;
   assign r_ready_o = d_ready_i;
   assign d_sof_o   = r_sof_i;
   assign d_eol_o   = r_eol_i;
   assign d_data_o  = r_data_i;

   // Frame sequencing; the last feed beat may jump straight to DONE when the results are already in.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= StIdle;
         r_width  <= '0;
         r_height <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_rrow   <= '0;
         r_cfgErr <= 1'b0;
      end else begin
         r_cfgErr <= 1'b0;
         if (abort_i && (r_state != StIdle)) begin
            r_state <= StIdle;
            r_col   <= '0;
            r_row   <= '0;
            r_rrow  <= '0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (start_i && !abort_i) begin
                     if (w_cfgOk) begin
                        r_state  <= StFeed;
                        r_width  <= cfg_width_i;
                        r_height <= cfg_height_i;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_rrow   <= '0;
                     end else begin
                        r_cfgErr <= 1'b1;
                     end
                  end
               end
               StFeed: begin
                  r_rrow <= w_rrowNext;
                  if (w_mXfer) begin
                     if (w_lastCol) begin
                        r_col <= '0;
                        r_row <= r_row + One;
                        if (w_lastRow) begin
                           r_state <= (w_rrowNext == r_height) ? StDone : StDrain;
                        end
                     end else begin
                        r_col <= r_col + One;
                     end
                  end
               end
               StDrain: begin
                  r_rrow <= w_rrowNext;
                  if (w_rrowNext == r_height) begin
                     r_state <= StDone;
                  end
               end
               StDone: begin
                  r_state <= StIdle;
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule
